// File: rtl/register_file.sv
// 32 x N register file: three combinational read ports, one write port, x0 hardwired to zero,
// plus a 16-bit count of committed writes.
module register_file #(
  parameter int unsigned N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [4:0]   rs1,
  input  logic [4:0]   rs2,
  input  logic [4:0]   rd,
  input  logic         regWrite,
  input  logic [N-1:0] writeData,
  input  logic [4:0]   dbgAddr,
  output logic [N-1:0] readData1,
  output logic [N-1:0] readData2,
  output logic [N-1:0] dbgData,
  output logic [15:0]  writeCount
);

  logic [N-1:0] regs_q [32];
  logic [15:0]  count_q;
  logic         commit;

  assign commit = regWrite && (rd != 5'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= '0;
      end
      count_q <= '0;
    end else if (commit) begin
      regs_q[rd] <= writeData;
      count_q    <= count_q + 16'd1;
    end
  end

  // x0 is gated on the read side so it reads zero even before the first reset.
  always_comb begin
    readData1 = (rs1 == 5'd0) ? '0 : regs_q[rs1];
    readData2 = (rs2 == 5'd0) ? '0 : regs_q[rs2];
    dbgData   = (dbgAddr == 5'd0) ? '0 : regs_q[dbgAddr];
  end

  assign writeCount = count_q;

endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 The block SHALL have parameter N, default 32, the data width in bits of every register and data port.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-004 rs1  input  5  read address, port 1; in a single-cycle core this feeds the shifter/ALU operand a.
REQ-005 rs2  input  5  read address, port 2; its data bits [4:0] supply the register shift amount.
REQ-006 rd  input  5  write address.
REQ-007 regWrite  input  1  write enable.
REQ-008 writeData  input  N  write data, i.e. the shifter/ALU result selected for writeback.
REQ-009 dbgAddr  input  5  debug/display read address.
REQ-010 readData1  output  N  contents of register rs1.
REQ-011 readData2  output  N  contents of register rs2.
REQ-012 dbgData  output  N  contents of register dbgAddr.
REQ-013 writeCount  output  16  number of committed writes since reset.

Function
REQ-014 Storage SHALL be 32 registers x0..x31, each N bits.
REQ-015 All three read ports SHALL be combinational: output = current register contents, with no added latency.
REQ-016 A write SHALL commit on the rising edge of clk when regWrite=1, rst=0 and rd!=0.
REQ-017 Write latency SHALL be one cycle: the new value is visible on the read ports after the committing edge, not before.
REQ-018 Read of rd in the same cycle as its write SHALL return the old value; there SHALL be no write-through bypass.
REQ-019 x0 SHALL always read 0 on every port; writes with rd=0 SHALL be discarded.
REQ-020 When rd=0 and regWrite=1, writeCount SHALL NOT increment.
REQ-021 writeCount SHALL increment by 1 on each committed write.
REQ-022 writeCount SHALL wrap from 0xFFFF to 0x0000 without saturating.
REQ-023 rs1, rs2 and dbgAddr SHALL be allowed to equal each other and rd simultaneously; every port returns the same pre-edge value.
REQ-024 Only one write port SHALL exist; no arbitration is needed.
REQ-025 X or Z on regWrite is out of scope; inputs are assumed driven at the sampling edge.

Reset
REQ-026 On a rising clk edge with rst=1, all 32 registers and writeCount SHALL become 0.
REQ-027 While rst=1, a write SHALL be ignored; rst takes priority over regWrite.
REQ-028 During and immediately after reset, readData1, readData2 and dbgData SHALL read 0 for any address.
REQ-029 rst asserted mid-program SHALL discard all prior contents in the same edge; no partial state SHALL be retained.

Verification
REQ-030 Reset then read: assert rst for 2 cycles, sweep rs1/rs2/dbgAddr 0..31 -> all outputs 0, writeCount=0.
REQ-031 Write then read: rd=5, writeData=0xDEADBEEF, regWrite=1 for one edge; rs1=5 -> readData1=0xDEADBEEF from the next cycle; during the write cycle readData1=0; writeCount=1.
REQ-032 x0 immunity: rd=0, writeData=0xFFFFFFFF, regWrite=1 -> rs1=0 reads 0, writeCount unchanged.
REQ-033 Shift-operand path: write x7=0x80000000 and x8=0x00000004; rs1=7, rs2=8 -> readData1=0x80000000, readData2[4:0]=4, so a downstream arithmetic right shift yields 0xF8000000.
REQ-034 Reset priority: regWrite=1, rd=3, writeData=0x1234, rst=1 on the same edge -> x3 reads 0, writeCount=0.
REQ-035 Counter wrap: perform 65536 committed writes -> writeCount returns to 0x0000; 65537 writes -> 0x0001.
